// File: rtl/clk_pulse_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_pulse_gen_pkg
// Brief    : Shared types for the multi-channel clock/pulse generator.
// Revision : 1.0 - initial release
// ============================================================================
package clk_pulse_gen_pkg;

  // Default counter / config field width.
  localparam int CNT_W_DEF = 16;

  // Per-channel waveform state.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PHASE = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } chan_state_e;

  // One channel's programmable timing, at the default field width.
  typedef struct packed {
    logic [CNT_W_DEF-1:0] phase;
    logic [CNT_W_DEF-1:0] ton;
    logic [CNT_W_DEF-1:0] toff;
  } chan_cfg_t;

endpackage
`default_nettype wire

// File: rtl/clk_pulse_gen_multi_chan.sv
`default_nettype none
// ============================================================================
// Module   : clk_pulse_chan
// Brief    : One waveform channel: staging/active config, pending flag,
//            IDLE/PHASE/HIGH/LOW sequencer with a down-counter, and
//            registered clk_out / period_start / busy.
// Revision : 1.0 - initial release
// ============================================================================
module clk_pulse_chan
  import clk_pulse_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_phase,
  input  logic [CNT_W-1:0] i_ton,
  input  logic [CNT_W-1:0] i_toff,
  input  logic             i_en,
  output logic             o_clk_out,
  output logic             o_period_start,
  output logic             o_busy
);

  // Config record at this instance's counter width.
  typedef struct packed {
    logic [CNT_W-1:0] phase;
    logic [CNT_W-1:0] ton;
    logic [CNT_W-1:0] toff;
  } cfg_t;

  localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);

  cfg_t             r_stage;
  cfg_t             r_active;
  logic             r_pend;
  chan_state_e      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_hent;      // state entered HIGH at the last edge
  logic             r_clk_out;
  logic             r_pstart;
  logic             r_busy;

  cfg_t             w_next;      // config that a load at this edge would use

  // A pending write supersedes the running config whenever a load happens.
  assign w_next = r_pend ? r_stage : r_active;

  // Segment load for LOW: a zero-length LOW holds cnt at 0 so the channel
  // re-examines its config every cycle instead of wrapping to the maximum.
  function automatic logic [CNT_W-1:0] seg_load(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : (v - c_ONE);
  endfunction

  // Channel sequencer, config staging and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stage   <= '0;
      r_active  <= '0;
      r_pend    <= 1'b0;
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_hent    <= 1'b0;
      r_clk_out <= 1'b0;
      r_pstart  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      // Outputs trail the state by one cycle; a dropped enable zeroes them
      // immediately so nothing leaks out after the channel is stopped.
      r_clk_out <= i_en && (r_state == HIGH);
      r_busy    <= i_en && (r_state != IDLE);
      r_pstart  <= i_en && r_hent;
      r_hent    <= 1'b0;

      if (!i_en) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_active <= w_next;
            r_pend   <= 1'b0;
            if (w_next.phase != '0) begin
              r_state <= PHASE;
              r_cnt   <= w_next.phase - c_ONE;
            end else if (w_next.ton != '0) begin
              r_state <= HIGH;
              r_cnt   <= w_next.ton - c_ONE;
              r_hent  <= 1'b1;
            end else begin
              r_state <= LOW;
              r_cnt   <= seg_load(w_next.toff);
            end
          end

          PHASE: begin
            if (r_cnt == '0) begin
              if (r_active.ton != '0) begin
                r_state <= HIGH;
                r_cnt   <= r_active.ton - c_ONE;
                r_hent  <= 1'b1;
              end else begin
                r_state <= LOW;
                r_cnt   <= seg_load(r_active.toff);
              end
            end else begin
              r_cnt <= r_cnt - c_ONE;
            end
          end

          HIGH: begin
            if (r_cnt == '0) begin
              if (r_active.toff != '0) begin
                // Mid-period: keep the running config.
                r_state <= LOW;
                r_cnt   <= r_active.toff - c_ONE;
              end else begin
                // toff==0 makes the end of HIGH a period boundary.
                r_active <= w_next;
                r_pend   <= 1'b0;
                if (w_next.ton != '0) begin
                  r_state <= HIGH;
                  r_cnt   <= w_next.ton - c_ONE;
                  r_hent  <= 1'b1;
                end else begin
                  r_state <= LOW;
                  r_cnt   <= seg_load(w_next.toff);
                end
              end
            end else begin
              r_cnt <= r_cnt - c_ONE;
            end
          end

          LOW: begin
            if (r_cnt == '0) begin
              // Period boundary: adopt any staged config.
              r_active <= w_next;
              r_pend   <= 1'b0;
              if (w_next.ton != '0) begin
                r_state <= HIGH;
                r_cnt   <= w_next.ton - c_ONE;
                r_hent  <= 1'b1;
              end else begin
                r_state <= LOW;
                r_cnt   <= seg_load(w_next.toff);
              end
            end else begin
              r_cnt <= r_cnt - c_ONE;
            end
          end

          default: begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end
        endcase
      end

      // A write landing on the same edge as a load stays pending for the
      // next boundary; placed last so it overrides the clear above.
      if (i_wr) begin
        r_stage <= {i_phase, i_ton, i_toff};
        r_pend  <= 1'b1;
      end
    end
  end

  assign o_clk_out      = r_clk_out;
  assign o_period_start = r_pstart;
  assign o_busy         = r_busy;

endmodule
`default_nettype wire

// File: rtl/clk_pulse_gen_multi.sv
`default_nettype none
// ============================================================================
// Module   : clk_pulse_gen_multi
// Brief    : NUM_CH independent programmable clock/pulse generators sharing
//            one config write port. Out-of-range channel writes are dropped.
// Revision : 1.0 - initial release
// ============================================================================
module clk_pulse_gen_multi
  import clk_pulse_gen_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int CNT_W  = CNT_W_DEF,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_chan,
  input  logic [CNT_W-1:0]  cfg_phase,
  input  logic [CNT_W-1:0]  cfg_ton,
  input  logic [CNT_W-1:0]  cfg_toff,
  input  logic [NUM_CH-1:0] en,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] period_start,
  output logic [NUM_CH-1:0] busy
);

  logic r_cfg_ready;
  logic w_cfg_acc;

  // Ready rises on the first edge out of reset and never drops afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg_ready <= 1'b0;
    end else begin
      r_cfg_ready <= 1'b1;
    end
  end

  assign cfg_ready = r_cfg_ready;
  assign w_cfg_acc = cfg_valid && r_cfg_ready;

  // One channel per output bit; each decodes its own write strobe, so a
  // code with no matching channel simply writes nothing.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
    logic w_wr;
    assign w_wr = w_cfg_acc && (cfg_chan == CH_W'(gi));

    clk_pulse_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk            (clk),
      .rst            (rst),
      .i_wr           (w_wr),
      .i_phase        (cfg_phase),
      .i_ton          (cfg_ton),
      .i_toff         (cfg_toff),
      .i_en           (en[gi]),
      .o_clk_out      (clk_out[gi]),
      .o_period_start (period_start[gi]),
      .o_busy         (busy[gi])
    );
  end

endmodule
`default_nettype wire
